// File: rtl/di_pkg.sv
// Shared constants and state encoding for the DI register-bus master arbiter.
package di_pkg;

    localparam int unsigned DI_W = 16;
    localparam int unsigned DI_DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } di_state_t;

endpackage

// File: rtl/di_rr_pick.sv
// Combinational round-robin select: first set request bit searching upward from last+1 with wrap.
module di_rr_pick #(
    parameter int unsigned NUM = 2,
    parameter int unsigned IW  = 1
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NUM-1:0] winner,
    output logic [IW-1:0]  idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NUM; k++) begin
            cand = (32'(last) + k) % NUM;
            if (!found && req[cand]) begin
                winner[cand] = 1'b1;
                idx          = IW'(cand);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/di_master_arbiter.sv
// Round-robin arbiter sharing the DI register bus between NUM_MASTERS requesters,
// issuing one-cycle strobes and waiting (with timeout) for the slave handshake.
module di_master_arbiter
    import di_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = DI_DEFAULT_TIMEOUT
) (
    input  logic                        if_clock,
    input  logic                        reset,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0]      m_write,
    input  logic [16*NUM_MASTERS-1:0]   m_ep_addr,
    input  logic [16*NUM_MASTERS-1:0]   m_reg_addr,
    input  logic [16*NUM_MASTERS-1:0]   m_wdata,
    output logic [NUM_MASTERS-1:0]      m_grant,
    output logic [NUM_MASTERS-1:0]      m_done,
    output logic                        m_err,
    output logic [15:0]                 m_rdata,
    output logic [15:0]                 diEpAddr,
    output logic [15:0]                 diRegAddr,
    output logic [15:0]                 diRegDataIn,
    output logic                        diWrite,
    output logic                        diRead,
    input  logic [15:0]                 diRegDataOut,
    input  logic                        rdwr_ready
);

    localparam int unsigned IW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_MASTERS - 1);

    di_state_t              state;
    logic                   write_flag;
    logic [15:0]            wait_cnt;
    logic [IW-1:0]          last;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]          pick_idx;

    di_rr_pick #(
        .NUM (NUM_MASTERS),
        .IW  (IW)
    ) u_pick (
        .req    (m_req),
        .last   (last),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge if_clock) begin
        if (reset) begin
            state       <= IDLE;
            write_flag  <= 1'b0;
            wait_cnt    <= '0;
            last        <= LAST_INIT;
            m_grant     <= '0;
            m_done      <= '0;
            m_err       <= 1'b0;
            m_rdata     <= '0;
            diEpAddr    <= '0;
            diRegAddr   <= '0;
            diRegDataIn <= '0;
            diWrite     <= 1'b0;
            diRead      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|m_req) begin
                        diEpAddr    <= m_ep_addr[pick_idx*DI_W +: DI_W];
                        diRegAddr   <= m_reg_addr[pick_idx*DI_W +: DI_W];
                        diRegDataIn <= m_wdata[pick_idx*DI_W +: DI_W];
                        write_flag  <= m_write[pick_idx];
                        // Strobes are registered here so they are high during the ISSUE cycle itself.
                        diWrite     <= m_write[pick_idx];
                        diRead      <= ~m_write[pick_idx];
                        m_grant     <= pick_onehot;
                        last        <= pick_idx;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    diWrite  <= 1'b0;
                    diRead   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (rdwr_ready) begin
                        if (!write_flag) begin
                            m_rdata <= diRegDataOut;
                        end
                        m_err  <= 1'b0;
                        m_done <= m_grant;
                        state  <= DONE;
                    end else if (wait_cnt == TO_LAST) begin
                        m_err  <= 1'b1;
                        m_done <= m_grant;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    m_done  <= '0;
                    m_grant <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
